// File: rtl/e_counter_checker_if.sv
// Sample/monitor bundle between a feedback-counter stream source and e_counter_checker.
// __output packs {locked, err, err_count[7:0], periods[15:0], expected[2W-1:0]}.
interface e_counter_checker_if #(
    parameter int unsigned W = 8
) ();
    logic               _i_valid;
    logic [2*W-1:0]     _i_sample;
    logic [2*W+25:0]    __output;

    modport master (
        output _i_valid,
        output _i_sample,
        input  __output
    );

    modport slave (
        input  _i_valid,
        input  _i_sample,
        output __output
    );
endinterface

// File: rtl/e_counter_checker.sv
// Monitor for the two-phase {x, y} counter stream: predicts each sample, counts errors and
// completed periods, and re-locks on the next (0,0) after a fault.
module e_counter_checker #(
    parameter int unsigned W     = 8,
    parameter int unsigned X_MAX = 8,
    parameter int unsigned Y_MAX = 6
) (
    input logic               _i_clk,
    input logic               _i_rst,
    e_counter_checker_if.slave chk
);

    typedef enum logic [1:0] {StSearch, StXph, StYph, StWrap} state_e;

    localparam logic [W-1:0] XMax = W'(X_MAX);
    localparam logic [W-1:0] YMax = W'(Y_MAX);
    localparam logic [W-1:0] One  = W'(1);
    localparam logic [W-1:0] Zero = '0;

    state_e         state_q, state_d;
    logic           locked_q, locked_d;
    logic           err_q, err_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic [15:0]    periods_q, periods_d;
    logic [2*W-1:0] exp_q, exp_d;

    logic [W-1:0]   exp_x, exp_y;
    logic           match;

    assign exp_x = exp_q[2*W-1:W];
    assign exp_y = exp_q[W-1:0];
    assign match = (chk._i_sample == exp_q);

    always_comb begin
        state_d   = state_q;
        locked_d  = locked_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        periods_d = periods_q;
        exp_d     = exp_q;
        if (chk._i_valid) begin
            if (state_q == StSearch) begin
                if (chk._i_sample == '0) begin
                    state_d  = StXph;
                    locked_d = 1'b1;
                    exp_d    = {One, Zero};
                end
            end else if (!match) begin
                // The faulty sample is consumed here; it never seeds the resync.
                err_d = 1'b1;
                if (err_cnt_q != 8'hff) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                locked_d = 1'b0;
                state_d  = StSearch;
                exp_d    = '0;
            end else begin
                case (state_q)
                    StXph: begin
                        if (exp_x == XMax) begin
                            if (Y_MAX == 0) begin
                                state_d = StWrap;
                                exp_d   = '0;
                            end else begin
                                state_d = StYph;
                                exp_d   = {XMax, One};
                            end
                        end else begin
                            exp_d = {exp_x + One, Zero};
                        end
                    end
                    StYph: begin
                        if (exp_y == YMax) begin
                            state_d = StWrap;
                            exp_d   = '0;
                        end else begin
                            exp_d = {XMax, exp_y + One};
                        end
                    end
                    StWrap: begin
                        periods_d = periods_q + 16'd1;
                        state_d   = StXph;
                        exp_d     = {One, Zero};
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge _i_clk or negedge _i_rst) begin
        if (!_i_rst) begin
            state_q   <= StSearch;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            periods_q <= '0;
            exp_q     <= '0;
        end else begin
            state_q   <= state_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            periods_q <= periods_d;
            exp_q     <= exp_d;
        end
    end

    assign chk.__output = {locked_q, err_q, err_cnt_q, periods_q, exp_q};

endmodule

// File: tb/tb_e_counter_checker.sv
// Self-checking bench for e_counter_checker: table vectors, a position-based stream model
// feeding a scoreboard queue, and hand-written reset / Y_MAX=0 sequences.
module tb_e_counter_checker;

    localparam int unsigned W  = 8;
    localparam int unsigned XM = 8;
    localparam int unsigned YM = 6;
    localparam int unsigned L  = XM + YM + 1;
    localparam int unsigned OW = 2 * W + 26;

    typedef struct {
        bit               v;
        logic [2*W-1:0]   s;
        logic [OW-1:0]    e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    e_counter_checker_if #(.W(W)) bus ();
    e_counter_checker_if #(.W(W)) bus0 ();

    e_counter_checker #(.W(W), .X_MAX(XM), .Y_MAX(YM)) dut (
        ._i_clk (clk),
        ._i_rst (rst_n),
        .chk    (bus)
    );

    e_counter_checker #(.W(W), .X_MAX(XM), .Y_MAX(0)) dut0 (
        ._i_clk (clk),
        ._i_rst (rst_n),
        .chk    (bus0)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [OW-1:0] sb_q[$];

    // Model tracks the position inside the legal period rather than FSM states.
    bit m_locked;
    int m_pos;
    bit m_err;
    int m_cnt;
    int m_per;

    function automatic logic [2*W-1:0] seq_at(input int p);
        if (p <= int'(XM)) return {W'(p), W'(0)};
        return {W'(XM), W'(p - int'(XM))};
    endfunction

    function automatic logic [OW-1:0] mk(input bit l, input bit e, input int c, input int p,
                                         input logic [2*W-1:0] x);
        return {l, e, 8'(c), 16'(p), x};
    endfunction

    function automatic logic [OW-1:0] model_out();
        return mk(m_locked, m_err, m_cnt, m_per, m_locked ? seq_at(m_pos) : {2*W{1'b0}});
    endfunction

    task automatic model_reset();
        m_locked = 0; m_pos = 0; m_err = 0; m_cnt = 0; m_per = 0;
    endtask

    task automatic model_step(input bit v, input logic [2*W-1:0] s);
        m_err = 0;
        if (v) begin
            if (!m_locked) begin
                if (s == '0) begin
                    m_locked = 1;
                    m_pos = 1;
                end
            end else if (s != seq_at(m_pos)) begin
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
                m_locked = 0;
            end else begin
                if (m_pos == 0) m_per = (m_per + 1) % 65536;
                m_pos = (m_pos + 1) % L;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic apply(input bit v, input logic [2*W-1:0] s, input bit use_model,
                         input logic [OW-1:0] tab_exp, input string name);
        bus._i_valid  = v;
        bus._i_sample = s;
        model_step(v, s);
        sb_q.push_back(use_model ? model_out() : tab_exp);
        @(posedge clk);
        #1;
        cmp(name, 64'(bus.__output), 64'(sb_q.pop_front()));
    endtask

    task automatic stream(input bit v, input logic [2*W-1:0] s);
        apply(v, s, 1'b1, '0, "stream");
    endtask

    task automatic legal_period();
        for (int p = 0; p < int'(L); p++) stream(1'b1, seq_at(p));
    endtask

    task automatic do_reset();
        bus._i_valid = 1'b0;
        bus0._i_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        sb_q.delete();
        #1;
        cmp("reset_out", 64'(bus.__output), 64'd0);
        cmp("reset_out0", 64'(bus0.__output), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tab[10];
    bit   gap[46];

    initial begin
        bus._i_valid = 1'b0;
        bus._i_sample = '0;
        bus0._i_valid = 1'b0;
        bus0._i_sample = '0;
        model_reset();
        #12;

        // Three legal periods plus the closing (0,0).
        do_reset();
        for (int k = 0; k < 3; k++) legal_period();
        stream(1'b1, '0);
        cmp("s1_periods", 64'(bus.__output[2*W +: 16]), 64'd3);
        cmp("s1_err_count", 64'(bus.__output[OW-3 -: 8]), 64'd0);

        // Same stream with five idle cycles sprinkled in.
        do_reset();
        for (int i = 0; i < 46; i++) gap[i] = 1'b0;
        for (int g = 0; g < 5; g++) begin
            int idx;
            idx = $urandom_range(45, 1);
            while (gap[idx]) idx = $urandom_range(45, 1);
            gap[idx] = 1'b1;
        end
        for (int i = 0; i < 46; i++) begin
            if (gap[i]) stream(1'b0, 16'($urandom));
            stream(1'b1, seq_at(i % int'(L)));
        end
        cmp("s2_periods", 64'(bus.__output[2*W +: 16]), 64'd3);
        cmp("s2_locked", 64'(bus.__output[OW-1]), 64'd1);

        // Fault: (5,0) replaced by (6,0), then resync on the next (0,0).
        tab[0] = '{1'b1, 16'h0000, mk(1, 0, 0, 0, 16'h0100)};
        tab[1] = '{1'b1, 16'h0100, mk(1, 0, 0, 0, 16'h0200)};
        tab[2] = '{1'b1, 16'h0200, mk(1, 0, 0, 0, 16'h0300)};
        tab[3] = '{1'b1, 16'h0300, mk(1, 0, 0, 0, 16'h0400)};
        tab[4] = '{1'b1, 16'h0400, mk(1, 0, 0, 0, 16'h0500)};
        tab[5] = '{1'b1, 16'h0600, mk(0, 1, 1, 0, 16'h0000)};
        tab[6] = '{1'b1, 16'h0700, mk(0, 0, 1, 0, 16'h0000)};
        tab[7] = '{1'b0, 16'h0000, mk(0, 0, 1, 0, 16'h0000)};
        tab[8] = '{1'b1, 16'h0000, mk(1, 0, 1, 0, 16'h0100)};
        tab[9] = '{1'b1, 16'h0100, mk(1, 0, 1, 0, 16'h0200)};
        do_reset();
        for (int i = 0; i < 10; i++) apply(tab[i].v, tab[i].s, 1'b0, tab[i].e, "s3_table");
        for (int p = 2; p < int'(L); p++) stream(1'b1, seq_at(p));
        stream(1'b1, '0);
        cmp("s3_periods", 64'(bus.__output[2*W +: 16]), 64'd1);
        cmp("s3_err_count", 64'(bus.__output[OW-3 -: 8]), 64'd1);

        // 300 periods, each followed by one fault: error count saturates.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            legal_period();
            stream(1'b1, '0);
            stream(1'b1, 16'h0300);
        end
        cmp("s4_err_count", 64'(bus.__output[OW-3 -: 8]), 64'd255);
        cmp("s4_periods", 64'(bus.__output[2*W +: 16]), 64'd300);

        // Reset in the middle of the Y phase, right after (8,3).
        do_reset();
        for (int p = 0; p <= int'(XM) + 3; p++) stream(1'b1, seq_at(p));
        bus._i_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp("s5_async_clear", 64'(bus.__output), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stream(1'b1, {W'(XM), W'(4)});
        cmp("s5_locked", 64'(bus.__output[OW-1]), 64'd0);
        cmp("s5_err", 64'(bus.__output[OW-2]), 64'd0);

        // Y_MAX=0 build: (0,0)..(8,0),(0,0) closes one period.
        for (int p = 0; p <= int'(XM) + 1; p++) begin
            bus0._i_valid = 1'b1;
            bus0._i_sample = (p <= int'(XM)) ? {W'(p), W'(0)} : '0;
            @(posedge clk);
            #1;
            cmp("s6_err", 64'(bus0.__output[OW-2]), 64'd0);
        end
        bus0._i_valid = 1'b0;
        cmp("s6_final", 64'(bus0.__output), 64'(mk(1, 0, 0, 1, 16'h0100)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
